screen_overlay_ctrl: RTL

Match-flow controller for the full-screen win-text overlays. Tracks each player's score from hit pulses and sequences PLAY -> P1_WIN / P2_WIN -> RESTART. It selects, per pixel, between the game renderer and the player1/player2 win-text renderers. Overlay changes are applied only at frame boundaries, so a frame never shows two sources. Sits between the game renderer, the two win-text example blocks and the VGA output pins.

---
 rtl/screen_pkg.sv | 7 +
 rtl/frame_tick_gen.sv | 22 ++
 rtl/screen_overlay_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/screen_pkg.sv
// screen_pkg: shared match-state, overlay and colour types for the overlay screens
package screen_pkg;
  typedef enum logic [1:0] {PLAY, P1_WIN, P2_WIN, RESTART} match_state_t;
  typedef enum logic [1:0] {OVL_NONE, OVL_P1, OVL_P2} overlay_t;
  typedef struct packed {logic [3:0] r, g, b;} rgb12_t;
  localparam rgb12_t RGB_BLACK = '0;
endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: one-shot pulse on entering (0,0) plus blank delayed two cycles to meet the colour pipeline
module frame_tick_gen
  import screen_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       blank,
  output logic       frame_tick,
  output logic       blank_d
);
  logic       at_origin, at_origin_q;
  logic [1:0] blank_q;
  assign at_origin  = DrawX == '0 && DrawY == '0;
  assign frame_tick = at_origin && !at_origin_q;
  assign blank_d    = blank_q[1];
  always_ff @(posedge clk) begin
    at_origin_q <= rst ? 1'b0 : at_origin;
    blank_q     <= rst ? 2'b00 : {blank_q[0], blank};
  end
endmodule

// File: rtl/screen_overlay_ctrl.sv
// screen_overlay_ctrl: score/win/restart flow with frame-aligned overlay muxing; SCREEN_OVERLAY_TRANSPARENT_EN lets KEY_RGB overlay pixels show the game
module screen_overlay_ctrl
  import screen_pkg::*;
#(
  parameter int          WIN_SCORE   = 3,
  parameter int          HOLD_FRAMES = 180,
  parameter logic [11:0] KEY_RGB     = 12'h000,
  localparam int         SW          = $clog2(WIN_SCORE + 1)
) (
  input  logic          vga_clk,
  input  logic          reset,
  input  logic [9:0]    DrawX,
  input  logic [9:0]    DrawY,
  input  logic          blank,
  input  logic          p1_hit,
  input  logic          p2_hit,
  input  logic          restart_btn,
  input  logic [3:0]    game_r,
  input  logic [3:0]    game_g,
  input  logic [3:0]    game_b,
  input  logic [3:0]    p1w_r,
  input  logic [3:0]    p1w_g,
  input  logic [3:0]    p1w_b,
  input  logic [3:0]    p2w_r,
  input  logic [3:0]    p2w_g,
  input  logic [3:0]    p2w_b,
  output logic [3:0]    red,
  output logic [3:0]    green,
  output logic [3:0]    blue,
  output logic [SW-1:0] p1_score,
  output logic [SW-1:0] p2_score,
  output logic          game_freeze,
  output logic          game_restart
);
`ifdef SCREEN_OVERLAY_TRANSPARENT_EN
  localparam bit TRANSPARENT = 1'b1;
`else
  localparam bit TRANSPARENT = 1'b0;
`endif
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  match_state_t  state, state_n;
  overlay_t      overlay_q;
  logic [HW-1:0] hold_cnt;
  logic          frame_tick, blank_d, btn_q, in_win, p1_only, p2_only, restart_ok;
  rgb12_t        game, p1w, p2w, sel, pix;
  frame_tick_gen u_tick (
    .clk       (vga_clk),
    .rst       (reset),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .blank     (blank),
    .frame_tick(frame_tick),
    .blank_d   (blank_d)
  );
  assign game       = {game_r, game_g, game_b};
  assign p1w        = {p1w_r, p1w_g, p1w_b};
  assign p2w        = {p2w_r, p2w_g, p2w_b};
  assign in_win     = state == P1_WIN || state == P2_WIN;
  assign p1_only    = state == PLAY && p1_hit && !p2_hit;
  assign p2_only    = state == PLAY && p2_hit && !p1_hit;
  assign restart_ok = restart_btn && !btn_q && hold_cnt == HW'(HOLD_FRAMES);
  always_ff @(posedge vga_clk)
    state <= reset ? PLAY : state_n;
  always_comb begin
    state_n = state == PLAY    ? (p1_only && p1_score == SW'(WIN_SCORE - 1) ? P1_WIN :
                                  p2_only && p2_score == SW'(WIN_SCORE - 1) ? P2_WIN : PLAY) :
              state == RESTART ? (frame_tick ? PLAY : RESTART) :
              restart_ok       ? RESTART : state;
  end
  always_comb begin
    game_freeze  = state != PLAY;
    game_restart = state == RESTART && frame_tick && !reset;
  end
  always_ff @(posedge vga_clk) begin
    if (reset || game_restart) begin
      p1_score <= '0;
      p2_score <= '0;
    end else begin
      if (p1_only && p1_score != SW'(WIN_SCORE)) p1_score <= p1_score + 1'b1;
      if (p2_only && p2_score != SW'(WIN_SCORE)) p2_score <= p2_score + 1'b1;
    end
  end
  always_ff @(posedge vga_clk) begin
    btn_q     <= reset ? 1'b0 : restart_btn;
    hold_cnt  <= (reset || !in_win) ? '0 :
                 (frame_tick && hold_cnt != HW'(HOLD_FRAMES)) ? hold_cnt + 1'b1 : hold_cnt;
    overlay_q <= reset ? OVL_NONE :
                 !frame_tick ? overlay_q :
                 state == P1_WIN ? OVL_P1 : state == P2_WIN ? OVL_P2 : OVL_NONE;
  end
  always_comb begin
    sel = overlay_q == OVL_P1 ? p1w : overlay_q == OVL_P2 ? p2w : game;
    pix = !blank_d ? RGB_BLACK :
          (TRANSPARENT && overlay_q != OVL_NONE && sel == KEY_RGB) ? game : sel;
  end
  always_ff @(posedge vga_clk)
    {red, green, blue} <= reset ? RGB_BLACK : pix;
endmodule
